instruction_memory_loader: RTL
==============================

Name: instruction_memory_loader

Overview:
Parametrised instruction memory for the single-cycle/multi-cycle datapath. It adds a streaming program-load port with a valid/ready handshake, a post-reset clear sequence and a registered fetch port with a valid flag. It replaces a fixed, preloaded ROM. Programs are loaded by the testbench or a boot controller, and the fetch unit reads through the registered port.

Parameters:
INSTR_WIDTH, 19, instruction word width in bits
ADDR_WIDTH, 12, fetch/load address width
DEPTH, 4096, number of words; must be ≤ 2**ADDR_WIDTH and ≥ 2
FILL_WORD, 0 (INSTR_WIDTH bits), value written to every word during clear (NOP encoding)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
load_start  input  1  request to begin a program load at address 0
load_valid  input  1  load_data is valid this cycle
load_data  input  INSTR_WIDTH  instruction word to write
load_last  input  1  qualifies the final word of the program (with load_valid)
load_ready  output  1  block accepts a load word this cycle
load_done  output  1  one-cycle pulse when a load completes
load_err  output  1  sticky; load hit DEPTH words without load_last
load_count  output  ADDR_WIDTH+1  words written by the most recent load
fetch_en  input  1  fetch request
address  input  ADDR_WIDTH  fetch address
instruction  output  INSTR_WIDTH  registered fetched word
instr_valid  output  1  instruction holds data fetched in the previous cycle
busy  output  1  high in CLEAR or LOAD; fetches are ignored

Behaviour:
- Reset (rst=1 at an edge) sets:
  - state to CLEAR and clear pointer to 0;
  - instruction to 0, instr_valid to 0;
  - load_ready, load_done and load_err to 0;
  - load_count to 0.
- Reset has priority over everything. Reset mid-LOAD or mid-CLEAR abandons the operation and restarts CLEAR.
- States: CLEAR, RUN, LOAD.
- CLEAR:
  - Writes FILL_WORD to mem[ptr] and increments ptr, one word per cycle.
  - After writing DEPTH-1, moves to RUN. CLEAR lasts exactly DEPTH cycles after reset deasserts.
  - busy=1. load_start is ignored (not queued).
- RUN:
  - busy=0, load_ready=0.
  - If load_start=1, moves to LOAD next cycle: write pointer=0, load_count=0, load_err cleared.
  - If load_start and fetch_en occur in the same cycle, the fetch is still serviced.
- LOAD:
  - load_ready=1 and busy=1.
  - When load_valid and load_ready are both high, writes load_data to mem[wptr] and increments wptr and load_count.
  - If load_last=1 on an accepted word: moves to RUN next cycle, with load_done=1 for that one cycle.
  - If an accepted word is written at wptr=DEPTH-1 without load_last: load_err=1, load_done=1, and the state moves to RUN. Further load_valid is ignored (load_ready=0).
  - Words not written during a load keep their previous contents. Locations are not re-cleared.
  - load_start during LOAD is ignored.
- Fetch:
  - Only in RUN. fetch_en=1 at edge N gives instruction=mem[address] and instr_valid=1 after edge N (1-cycle latency).
  - fetch_en=0 in RUN gives instr_valid=0 next cycle; instruction holds its last value.
  - In CLEAR or LOAD, instr_valid=0 and instruction holds.
  - Address ≥ DEPTH returns FILL_WORD with instr_valid=1 (no wrap, no error).
- Read-during-write cannot occur: loads and fetches are mutually exclusive by state.
- load_count saturates at DEPTH. It holds its value after the load until the next load_start.
- load_done is never high in consecutive cycles.

Test Plan:
- Clear: rst high 2 cycles, then low; DEPTH=16 → busy=1 for 16 cycles. Every fetch of addresses 0..15 then returns 0 with instr_valid=1 one cycle later.
- Load/fetch:
  - Stimulus: load_start, then words 19'h0A560, 19'h04B60, 19'h0E1C0 (last on third), with load_valid gaps.
  - Required: load_done pulse once, load_count=3.
  - Fetches of addresses 0, 1, 2 return those words at 1-cycle latency; address 3 returns 0.
- Overflow, DEPTH=16: 16 accepted words with no load_last → load_err=1, load_done pulse, load_count=16, load_ready=0 afterwards. A 17th valid word does not modify mem[0].
- Busy gating: fetch_en held high during LOAD → instr_valid=0 and instruction unchanged. First RUN cycle with fetch_en → valid data next cycle.
- Reset mid-load: rst after 2 of 5 words → CLEAR restarts, load_count=0, all locations read FILL_WORD afterwards.
- Out-of-range: DEPTH=16, ADDR_WIDTH=12, fetch address 12'h020 → instruction=FILL_WORD, instr_valid=1. Simultaneous load_start+fetch_en in RUN → fetch data valid, LOAD entered next cycle.

Source files
------------

// File: rtl/instruction_memory_loader.sv
// Instruction memory with a post-reset clear sweep, a streaming valid/ready program-load port
// and a registered fetch port. Loads and fetches are mutually exclusive by state.
module instruction_memory_loader #(
    parameter int unsigned             INSTR_WIDTH = 19,
    parameter int unsigned             ADDR_WIDTH  = 12,
    parameter int unsigned             DEPTH       = 4096,
    parameter logic [INSTR_WIDTH-1:0]  FILL_WORD   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   load_valid,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   load_last,
    output logic                   load_ready,
    output logic                   load_done,
    output logic                   load_err,
    output logic [ADDR_WIDTH:0]    load_count,
    input  logic                   fetch_en,
    input  logic [ADDR_WIDTH-1:0]  address,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic                   busy
);

    localparam int unsigned            IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0]  LastPtr  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]    DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {StClear, StRun, StLoad} state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]      count_q, count_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic                     valid_q, valid_d;

    logic                     mem_we;
    logic [INSTR_WIDTH-1:0]   mem_wdata;
    logic [INSTR_WIDTH-1:0]   mem_q [DEPTH];

    logic                     in_range;
    logic [INSTR_WIDTH-1:0]   rd_word;

    // Addresses beyond the populated depth read as the fill word rather than aliasing.
    assign in_range = {1'b0, address} < DepthCnt;
    assign rd_word  = in_range ? mem_q[address[IdxW-1:0]] : FILL_WORD;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        done_d    = 1'b0;
        err_d     = err_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = FILL_WORD;

        unique case (state_q)
            StClear: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == LastPtr) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (fetch_en) begin
                    instr_d = rd_word;
                    valid_d = 1'b1;
                end
                if (load_start) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                if (load_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = load_data;
                    ptr_d     = ptr_q + 1'b1;
                    count_d   = count_q + 1'b1;
                    // A full memory without load_last terminates the load as an error.
                    if (load_last || (ptr_q == LastPtr)) begin
                        state_d = StRun;
                        done_d  = 1'b1;
                        err_d   = ~load_last;
                    end
                end
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            ptr_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[ptr_q[IdxW-1:0]] <= mem_wdata;
        end
    end

    assign load_ready  = (state_q == StLoad);
    assign busy        = (state_q != StRun);
    assign load_done   = done_q;
    assign load_err    = err_q;
    assign load_count  = count_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;

endmodule
